// File: rtl/rezultat_bcd_if.sv
// Adder-result to display-converter bus: signed sum in, sign + packed BCD out.
interface rezultat_bcd_if #(
    parameter int W      = 28,
    parameter int DIGITS = 8
);
    logic                  valid_in;
    logic                  ovrflow_in;
    logic [W-1:0]          d_in;
    logic                  busy;
    logic                  valid_out;
    logic                  negativ;
    logic                  eroare;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output valid_in, ovrflow_in, d_in,
        input  busy, valid_out, negativ, eroare, bcd_out
    );

    modport slave (
        input  valid_in, ovrflow_in, d_in,
        output busy, valid_out, negativ, eroare, bcd_out
    );
endinterface

// File: rtl/rezultat_bcd.sv
// Signed binary result to sign + packed BCD, sequential double-dabble
// (one shift per clock); out-of-range or overflowed results are flagged.
module rezultat_bcd #(
    parameter int W      = 28,
    parameter int DIGITS = 8,
    parameter int MAXVAL = 99999999
) (
    input  logic           clk,
    input  logic           rst,
    rezultat_bcd_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0]  MAXV = W'(MAXVAL);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, ABS, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic             valid_in_q;
    logic [W-1:0]     d_q;
    logic             ovf_q;
    logic             sign_q;
    logic [BW+W-1:0]  sr;
    logic [BW+W-1:0]  adj;
    logic [BW+W-1:0]  sr_nxt;
    logic [CW-1:0]    cnt;
    logic [W-1:0]     mag;
    logic             err;
    logic             cap;
    logic             last;
    logic [BW-1:0]    bcd_q;
    logic             neg_q;
    logic             err_q;

    assign cap  = bus.valid_in & ~valid_in_q;
    assign last = (cnt == LAST);
    // -2**(W-1) negates to itself, which read unsigned is 2**(W-1) > MAXVAL
    assign mag  = d_q[W-1] ? (~d_q + {{(W-1){1'b0}}, 1'b1}) : d_q;
    assign err  = ovf_q | (mag > MAXV);

    always_comb begin
        adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[W+4*i +: 4] >= 4'd5)
                adj[W+4*i +: 4] = adj[W+4*i +: 4] + 4'd3;
        end
        sr_nxt = {adj[BW+W-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cap) state_nxt = ABS;
            ABS:     state_nxt = err ? DONE : SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_in_q <= 1'b0;
            d_q        <= '0;
            ovf_q      <= 1'b0;
            sign_q     <= 1'b0;
            sr         <= '0;
            cnt        <= '0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_in_q <= bus.valid_in;
            case (state)
                IDLE: if (cap) begin
                    d_q   <= bus.d_in;
                    ovf_q <= bus.ovrflow_in;
                end
                ABS: begin
                    sign_q <= d_q[W-1] & (mag != '0);
                    if (err) begin
                        bcd_q <= '1;
                        neg_q <= 1'b0;
                        err_q <= 1'b1;
                    end else begin
                        sr  <= {{BW{1'b0}}, mag};
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    sr  <= sr_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        bcd_q <= sr_nxt[BW+W-1 -: BW];
                        neg_q <= sign_q;
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.valid_out = (state == DONE);
    assign bus.bcd_out   = bcd_q;
    assign bus.negativ   = neg_q;
    assign bus.eroare    = err_q;
endmodule

// File: tb/tb_rezultat_bcd.sv
// Directed + random bench for rezultat_bcd against an arithmetic reference model.
module tb_rezultat_bcd;
    localparam int W = 28;
    localparam int DIGITS = 8;
    localparam longint MAXVAL = 99999999;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    rezultat_bcd_if #(.W(W), .DIGITS(DIGITS)) bus ();

    rezultat_bcd #(.W(W), .DIGITS(DIGITS), .MAXVAL(99999999)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts in IDLE just after a posedge with valid_in low. valid_in is high
    // for edges 0..hold-1; if glitch_at > 0 it is raised again (with gval)
    // before that edge and held, which must not start a second conversion.
    task automatic conv(input logic signed [W-1:0] v, input bit ovf, input int hold,
                        input int glitch_at, input logic signed [W-1:0] gval);
        longint sv, mag, m;
        bit     e_err, e_neg;
        logic [31:0] e_bcd;
        int     e_lat, pulses;
        sv    = v;
        mag   = (sv < 0) ? -sv : sv;
        e_err = ovf || (mag > MAXVAL);
        if (e_err) begin
            e_bcd = 32'hFFFF_FFFF; e_neg = 1'b0; e_lat = 1;
        end else begin
            e_bcd = '0; m = mag;
            for (int i = 0; i < DIGITS; i++) begin
                e_bcd[4*i +: 4] = 4'(m % 10);
                m = m / 10;
            end
            e_neg = (sv < 0); e_lat = W + 1;
        end
        bus.d_in = v; bus.ovrflow_in = ovf; bus.valid_in = 1'b1;
        pulses = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (e + 1 >= hold) bus.valid_in = 1'b0;
            if (glitch_at > 0 && e + 1 >= glitch_at) begin
                bus.valid_in = 1'b1;
                if (e + 1 == glitch_at) bus.d_in = gval;
            end
            if (e == 0) chk("busy_after_capture", 64'(bus.busy), 64'd1);
            if (bus.valid_out) begin
                pulses++;
                if (pulses == 1) begin
                    chk("latency", 64'(e), 64'(e_lat));
                    chk("busy_in_done", 64'(bus.busy), 64'd1);
                    chk("bcd_out", 64'(bus.bcd_out), 64'(e_bcd));
                    chk("negativ", 64'(bus.negativ), 64'(e_neg));
                    chk("eroare", 64'(bus.eroare), 64'(e_err));
                end
            end
        end
        bus.valid_in = 1'b0;
        chk("pulse_count", 64'(pulses), 64'd1);
        chk("busy_idle", 64'(bus.busy), 64'd0);
        chk("bcd_held", 64'(bus.bcd_out), 64'(e_bcd));
        @(posedge clk); #1;
    endtask

    initial begin
        int pulses;
        logic signed [W-1:0] rv;
        rst = 1'b1;
        bus.valid_in = 1'b0; bus.ovrflow_in = 1'b0; bus.d_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_valid", 64'(bus.valid_out), 64'd0);
        chk("rst_bcd", 64'(bus.bcd_out), 64'd0);
        chk("rst_neg", 64'(bus.negativ), 64'd0);
        chk("rst_err", 64'(bus.eroare), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        conv(28'sd3946, 1'b0, 3, 0, '0);
        conv(-28'sd2436, 1'b0, 1, 0, '0);
        conv(28'sd0, 1'b0, 1, 0, '0);
        conv(28'sd100000020, 1'b1, 3, 0, '0);
        conv(28'sd99999999, 1'b0, 1, 0, '0);
        conv(28'sd100000000, 1'b0, 1, 0, '0);
        conv(-28'sd134217728, 1'b0, 2, 0, '0);
        conv(-28'sd99999999, 1'b0, 1, 0, '0);
        conv(28'sd4321, 1'b0, 1, 10, 28'sd8765);
        conv(28'sd8765, 1'b0, 1, 0, '0);

        // Reset mid-conversion: nothing may come out for the aborted value
        bus.d_in = 28'sd1234; bus.ovrflow_in = 1'b0; bus.valid_in = 1'b1;
        pulses = 0;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk); #1;
            bus.valid_in = 1'b0;
            if (bus.valid_out) pulses++;
        end
        rst = 1'b1; #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_valid", 64'(bus.valid_out), 64'd0);
        chk("midrst_bcd", 64'(bus.bcd_out), 64'd0);
        chk("midrst_neg", 64'(bus.negativ), 64'd0);
        chk("midrst_err", 64'(bus.eroare), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int e = 0; e < 35; e++) begin
            @(posedge clk); #1;
            if (bus.valid_out) pulses++;
        end
        chk("midrst_no_pulse", 64'(pulses), 64'd0);
        conv(28'sd5678, 1'b0, 1, 0, '0);

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(3))
                0: rv = W'($urandom_range(9999));
                1: rv = W'(MAXVAL - 3 + $urandom_range(6));
                2: rv = W'($urandom);
                default: rv = -W'($urandom_range(99999999));
            endcase
            conv(rv, ($urandom_range(7) == 0), 1 + $urandom_range(3), 0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
